sram_arbiter: RTL

- Shares the single-port 8 KiB track-buffer SRAM between two requesters.
- Port A (flux/floppy side) streams track bytes; port B (host/loader side) performs random reads and writes.
- Issues at most one SRAM access per clock, drives the SRAM's en/rw/addr/data_in from registers, and returns read data with a fixed latency.
- Instantiated between the floppy engine, the host interface and the SRAM.

---
 rtl/sram_arbiter_pkg.sv | 19 +
 rtl/sram_arbiter_if.sv | 40 ++++
 rtl/sram_arb_rr2.sv | 62 ++++++
 rtl/sram_arbiter.sv | 89 ++++++++
 4 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the track-buffer SRAM arbiter: port encoding, default
// bus widths and the read-return tag carried through the command pipeline.
package sram_arbiter_pkg;

  localparam int ADDR_W_DEF = 13;
  localparam int DATA_W_DEF = 8;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  typedef struct packed {
    logic  vld;
    logic  is_rd;
    port_e port;
  } tag_t;

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester A/B handshakes plus the SRAM command/data bus; slave is the
// arbiter's view, master is the view of the surrounding logic.
interface sram_arbiter_if
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              a_req, a_we, a_gnt, a_rvalid;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata, a_rdata;

  logic              b_req, b_we, b_gnt, b_rvalid;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata, b_rdata;

  logic              sram_en, sram_rw;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_din, sram_dout;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    input  sram_dout,
    output a_gnt, a_rvalid, a_rdata,
    output b_gnt, b_rvalid, b_rdata,
    output sram_en, sram_rw, sram_addr, sram_din
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    output sram_dout,
    input  a_gnt, a_rvalid, a_rdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  sram_en, sram_rw, sram_addr, sram_din
  );

endinterface

// File: rtl/sram_arb_rr2.sv
// Two-way grant logic: sticky owner with a burst limit that hands over to the
// other port after MAX_BURST consecutive grants under contention.
module sram_arb_rr2
  import sram_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic a_req_i,
  input  logic b_req_i,
  output logic a_gnt_o,
  output logic b_gnt_o
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

  port_e            owner_q, owner_d, win;
  logic [CNT_W-1:0] burst_q, burst_d;
  logic             gnt_any, both;

  always_comb begin
    both    = a_req_i & b_req_i;
    gnt_any = 1'b0;
    win     = owner_q;
    // Grants are held off while in reset so the handshake outputs stay quiet.
    if (!rst) begin
      if (both) begin
        gnt_any = 1'b1;
        win     = (burst_q >= BURST_MAX) ? port_e'(~owner_q) : owner_q;
      end else if (a_req_i) begin
        gnt_any = 1'b1;
        win     = PORT_A;
      end else if (b_req_i) begin
        gnt_any = 1'b1;
        win     = PORT_B;
      end
    end

    owner_d = gnt_any ? win : owner_q;

    if (!both)                burst_d = '0;
    else if (win != owner_q)  burst_d = CNT_W'(1);
    else if (burst_q < BURST_MAX) burst_d = burst_q + CNT_W'(1);
    else                      burst_d = burst_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= PORT_A;
      burst_q <= '0;
    end else begin
      owner_q <= owner_d;
      burst_q <= burst_d;
    end
  end

  assign a_gnt_o = gnt_any & (win == PORT_A);
  assign b_gnt_o = gnt_any & (win == PORT_B);

endmodule

// File: rtl/sram_arbiter.sv
// Shares the single-port track-buffer SRAM between the flux stream (A) and the
// host (B): one registered command per clock, read data returned two cycles later.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = 4
) (
  input  logic           clk,
  input  logic           rst,
  sram_arbiter_if.slave  bus
);

  logic              a_gnt, b_gnt, gnt_any;
  logic              en_q, en_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  tag_t [2:1]        tag_q;
  tag_t              tag_d;
  logic              a_rvalid, b_rvalid;

  sram_arb_rr2 #(
    .MAX_BURST(MAX_BURST)
  ) u_rr2 (
    .clk     (clk),
    .rst     (rst),
    .a_req_i (bus.a_req),
    .b_req_i (bus.b_req),
    .a_gnt_o (a_gnt),
    .b_gnt_o (b_gnt)
  );

  always_comb begin
    gnt_any = a_gnt | b_gnt;
    en_d    = gnt_any;
    rw_d    = rw_q;
    addr_d  = addr_q;
    din_d   = din_q;
    // Command fields hold their last value when idle to avoid SRAM bus toggling.
    if (b_gnt) begin
      rw_d   = ~bus.b_we;
      addr_d = bus.b_addr;
      din_d  = bus.b_wdata;
    end else if (a_gnt) begin
      rw_d   = ~bus.a_we;
      addr_d = bus.a_addr;
      din_d  = bus.a_wdata;
    end
    tag_d.vld   = gnt_any;
    tag_d.is_rd = rw_d;
    tag_d.port  = b_gnt ? PORT_B : PORT_A;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q   <= 1'b0;
      rw_q   <= 1'b1;
      addr_q <= '0;
      din_q  <= '0;
      tag_q  <= '0;
    end else begin
      en_q     <= en_d;
      rw_q     <= rw_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      tag_q[1] <= tag_d;
      tag_q[2] <= tag_q[1];
    end
  end

  // Stage 2 lines up with the SRAM's registered read data.
  assign a_rvalid = tag_q[2].vld & tag_q[2].is_rd & (tag_q[2].port == PORT_A);
  assign b_rvalid = tag_q[2].vld & tag_q[2].is_rd & (tag_q[2].port == PORT_B);

  assign bus.a_gnt    = a_gnt;
  assign bus.b_gnt    = b_gnt;
  assign bus.a_rvalid = a_rvalid;
  assign bus.b_rvalid = b_rvalid;
  assign bus.a_rdata  = a_rvalid ? bus.sram_dout : '0;
  assign bus.b_rdata  = b_rvalid ? bus.sram_dout : '0;

  assign bus.sram_en   = en_q;
  assign bus.sram_rw   = rw_q;
  assign bus.sram_addr = addr_q;
  assign bus.sram_din  = din_q;

endmodule
